uart_frame_ctrl: RTL
====================

# uart_frame_ctrl

Frame-level receive controller sitting between `uart_rx` and the hasher input. Edge-detects the byte strobe from `uart_rx`, parses frames of the form SOF, LEN, payload, checksum, and buffers payload bytes in an internal FIFO. Payload bytes go out on a valid/ready stream with a last-byte tag. Reports frame start, success and error as single-cycle pulses, and recovers from timeouts, overflow and bad lengths without a reset.

## Interface
- `SOF_BYTE`, 8'hA5, start-of-frame byte.
- `FIFO_DEPTH`, 16, payload FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 50000, maximum gap in `clk` cycles between bytes within a frame.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  byte from `uart_rx`; valid while `rx_data_ready` is high.
- `rx_data_ready`  in  1  byte strobe from `uart_rx`; a byte is accepted on its rising edge only.
- `m_data`  out  8  payload byte at FIFO head.
- `m_last`  out  1  head byte is the final payload byte of its frame.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  downstream accepts; pop when `m_valid && m_ready`.
- `frame_start`  out  1  one-cycle pulse when SOF is accepted in IDLE.
- `frame_ok`  out  1  one-cycle pulse when a frame completes with a correct checksum.
- `frame_err`  out  1  one-cycle pulse on any frame error.
- `err_code`  out  2  last error: 00 checksum, 01 timeout, 10 overflow, 11 zero length; holds until the next error.

## Operation
- Byte accept: `acc = rx_data_ready & ~rx_q`, where `rx_q` is `rx_data_ready` registered. A level held high yields exactly one byte.
- States: IDLE, LEN, PAYLOAD, CSUM, DRAIN.
- IDLE:
  - `acc && rx_data==SOF_BYTE` → LEN; pulse `frame_start`.
  - Any other byte is ignored.
- LEN:
  - Byte 0 → `frame_err`, code 11, → IDLE.
  - Otherwise load 8-bit `remain` = byte and `sum` = byte, then → PAYLOAD.
- PAYLOAD, per accepted byte:
  - Push {byte, last = (`remain`==1)} into the FIFO.
  - `sum` += byte, mod 256; `remain` −= 1.
  - When `remain` reaches 0 → CSUM.
- CSUM, on accepted byte:
  - Byte == `sum` → `frame_ok`.
  - Otherwise → `frame_err`, code 00.
  - Either case → IDLE. The FIFO is not flushed on a checksum error; downstream discards on `frame_err`.
- Overflow: a push while the FIFO is full (occupancy at start of cycle, regardless of a same-cycle pop) → `frame_err`, code 10, flush FIFO, → DRAIN.
- DRAIN: discard all bytes; return to IDLE only after TIMEOUT_CYCLES with no accepted byte. No error is reported on that exit.
- Timeout counter:
  - Cleared on every `acc`; counts in LEN, PAYLOAD, CSUM and DRAIN; held at 0 in IDLE.
  - Reaching `TIMEOUT_CYCLES-1` in LEN, PAYLOAD or CSUM → `frame_err`, code 01, flush FIFO, → IDLE.
- Flush empties the FIFO in one cycle and takes priority over a same-cycle push and pop.
- At most one of `frame_ok` / `frame_err` per cycle. Pulses never repeat for the same event.

## Timing
- Reset values: state IDLE, FIFO empty, `m_valid` 0, `m_data` 0, `m_last` 0, `frame_start`/`frame_ok`/`frame_err` 0, `err_code` 00, `rx_q` 0, counters 0.
- `rst` mid-frame: abandon the frame, empty the FIFO, emit no pulse.
- `acc` in cycle N:
  - State, status pulses and FIFO write take effect at the clock edge ending cycle N.
  - Pulses are high during cycle N+1.
  - With the FIFO empty and `m_ready` high, the byte is visible on `m_data` with `m_valid`=1 in cycle N+1.
- `m_data` and `m_last` are combinational from the FIFO head and are 0 when empty. Pop takes effect at the same clock edge.
- Simultaneous push and pop with the FIFO neither empty nor full: occupancy unchanged.
- Throughput: one byte per cycle in and out. The FIFO exists only to absorb hasher stalls, since `uart_rx` cannot be back-pressured.

## Configuration
- `FRAME_CHECKSUM_EN` defined:
  - CSUM state present; frame layout is SOF, LEN, payload, checksum.
  - `frame_ok` pulses after a matching checksum byte.
- Undefined:
  - No CSUM state and no `sum` register; frame layout is SOF, LEN, payload.
  - `frame_ok` pulses in the cycle after the last payload byte is accepted, then → IDLE.
  - Error code 00 is never produced.

## Test plan
- Good frame: send A5 03 11 22 33 69 with `m_ready`=1 → one `frame_start`, then `m_data` 11, 22, 33 with `m_last` only on 33, then one `frame_ok`, `frame_err` never high.
- Bad checksum: send A5 02 10 20 00 → bytes 10 and 20 (last on 20) streamed, then `frame_err` with `err_code`=00, state IDLE.
- Zero length and noise: send 5A FF A5 00 → no response to 5A or FF, `frame_start` on A5, then `frame_err` with `err_code`=11, and the next valid frame is accepted.
- Timeout: send A5 04 01, then idle for `TIMEOUT_CYCLES` → `frame_err` with `err_code`=01, FIFO empty, state IDLE.
- Overflow: `FIFO_DEPTH`=16, `m_ready`=0, send A5 14 followed by 20 bytes → `frame_err` with `err_code`=10 on the 17th payload byte, FIFO empty, remaining bytes ignored, and IDLE after the idle gap.
- Held strobe and reset: hold `rx_data_ready` high with A5 for 10 cycles → exactly one `frame_start`; assert `rst` mid-payload → all outputs return to reset values with no pulse.

Source files
------------

// File: rtl/uart_frame_ctrl.sv
// ============================================================================
// uart_frame_ctrl
// ----------------------------------------------------------------------------
// Frame-level receive controller between uart_rx and the hasher input.
//
// A byte is taken from uart_rx on the rising edge of rx_data_ready. If the
// strobe is held high, it still counts as only one byte. Frames have the form
//   SOF, LEN, payload[LEN], checksum   (checksum only with FRAME_CHECKSUM_EN)
// Payload bytes are buffered in a small FIFO. They leave on a valid/ready
// stream, and the final byte of each frame carries a last tag.
//
// uart_rx cannot be back-pressured. The FIFO only absorbs downstream stalls.
// If a frame overruns the FIFO, the frame is dropped. The controller then
// waits in DRAIN for a quiet line before it hunts for SOF again.
//
// Compile-time option:
//   FRAME_CHECKSUM_EN  defined   -> trailing checksum byte is expected and
//                                   checked: sum(LEN, payload) mod 256
//                      undefined -> no checksum byte; frame_ok follows the
//                                   last payload byte
//
// Parameters:
//   SOF_BYTE        start-of-frame byte
//   FIFO_DEPTH      payload FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES  maximum clk cycles between bytes inside a frame
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   rx_data        byte from uart_rx, valid while rx_data_ready is high
//   rx_data_ready  byte strobe from uart_rx
//   m_data         payload byte at FIFO head (0 when empty)
//   m_last         head byte ends its frame (0 when empty)
//   m_valid        FIFO non-empty
//   m_ready        downstream accepts; pop on m_valid && m_ready
//   frame_start    1-cycle pulse: SOF accepted
//   frame_ok       1-cycle pulse: frame completed successfully
//   frame_err      1-cycle pulse: frame error
//   err_code       last error (00 checksum, 01 timeout, 10 overflow,
//                  11 zero length); holds until the next error
// ============================================================================
module uart_frame_ctrl #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         FIFO_DEPTH     = 16,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_start,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int              AW            = $clog2(FIFO_DEPTH);
  localparam int              TW            = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]     FIFO_FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0]   TMO_LAST      = TW'(TIMEOUT_CYCLES - 1);

`ifdef FRAME_CHECKSUM_EN
  localparam logic [1:0] ERR_CSUM = 2'b00;
`endif
  localparam logic [1:0] ERR_TMO  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_ZLEN = 2'b11;

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_DRAIN
  } state_t;
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic          rx_q_reg;
  logic [7:0]    remain_reg, remain_next;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    sum_reg, sum_next;
`endif
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          frame_start_reg, start_next;
  logic          frame_ok_reg, ok_next;
  logic          frame_err_reg, err_next;
  logic [1:0]    err_code_reg, code_next;

  // Payload FIFO: {last, data} per entry. The read is combinational from
  // the head, so a byte written at an edge appears on m_data right after it.
  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       acc;
  logic       tmo_hit;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       push_last;
  logic       flush;
  logic [8:0] fifo_head;

  // Rising edge of the strobe: a level held high yields exactly one byte.
  assign acc        = rx_data_ready & ~rx_q_reg;

  // A byte arriving in the same cycle as the limit restarts the gap.
  assign tmo_hit    = (tmo_reg == TMO_LAST) && !acc;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FIFO_FULL_CNT);
  assign pop        = !fifo_empty && m_ready;
  assign fifo_head  = fifo_mem[rd_ptr_reg];

  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_empty ? 8'h00 : fifo_head[7:0];
  assign m_last     = !fifo_empty && fifo_head[8];

  assign frame_start = frame_start_reg;
  assign frame_ok    = frame_ok_reg;
  assign frame_err   = frame_err_reg;
  assign err_code    = err_code_reg;

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
`ifdef FRAME_CHECKSUM_EN
    sum_next    = sum_reg;
`endif
    start_next  = 1'b0;
    ok_next     = 1'b0;
    err_next    = 1'b0;
    code_next   = err_code_reg;
    push        = 1'b0;
    push_last   = 1'b0;
    flush       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Anything other than SOF is line noise and is dropped silently.
        if (acc && rx_data == SOF_BYTE) begin
          state_next = S_LEN;
          start_next = 1'b1;
        end
      end

      S_LEN: begin
        if (acc) begin
          if (rx_data == 8'h00) begin
            err_next   = 1'b1;
            code_next  = ERR_ZLEN;
            state_next = S_IDLE;
          end else begin
            remain_next = rx_data;
`ifdef FRAME_CHECKSUM_EN
            // The length byte is part of the checksum.
            sum_next    = rx_data;
`endif
            state_next  = S_PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          code_next  = ERR_TMO;
          flush      = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_PAYLOAD: begin
        if (acc) begin
          // Fullness is judged on start-of-cycle occupancy. A same-cycle pop
          // does not rescue the byte.
          if (fifo_full) begin
            err_next   = 1'b1;
            code_next  = ERR_OVF;
            flush      = 1'b1;
            state_next = S_DRAIN;
          end else begin
            push        = 1'b1;
            push_last   = (remain_reg == 8'd1);
            remain_next = remain_reg - 8'd1;
`ifdef FRAME_CHECKSUM_EN
            sum_next    = sum_reg + rx_data;
            if (remain_reg == 8'd1) begin
              state_next = S_CSUM;
            end
`else
            if (remain_reg == 8'd1) begin
              ok_next    = 1'b1;
              state_next = S_IDLE;
            end
`endif
          end
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          code_next  = ERR_TMO;
          flush      = 1'b1;
          state_next = S_IDLE;
        end
      end

`ifdef FRAME_CHECKSUM_EN
      S_CSUM: begin
        if (acc) begin
          // The payload has already been streamed. On a bad checksum,
          // downstream drops it when it sees frame_err.
          if (rx_data == sum_reg) begin
            ok_next = 1'b1;
          end else begin
            err_next  = 1'b1;
            code_next = ERR_CSUM;
          end
          state_next = S_IDLE;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          code_next  = ERR_TMO;
          flush      = 1'b1;
          state_next = S_IDLE;
        end
      end
`endif

      S_DRAIN: begin
        // Swallow the rest of the overrun frame. Only a quiet line tells us
        // we are back at a frame boundary. This exit is silent.
        if (tmo_hit) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // The gap counter restarts on every byte. It stays at zero while
    // hunting for SOF.
    if (acc || tmo_hit || state_reg == S_IDLE) begin
      tmo_next = '0;
    end else begin
      tmo_next = tmo_reg + TW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // State and FIFO control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      rx_q_reg        <= 1'b0;
      remain_reg      <= 8'h00;
`ifdef FRAME_CHECKSUM_EN
      sum_reg         <= 8'h00;
`endif
      tmo_reg         <= '0;
      frame_start_reg <= 1'b0;
      frame_ok_reg    <= 1'b0;
      frame_err_reg   <= 1'b0;
      err_code_reg    <= 2'b00;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      rx_q_reg        <= rx_data_ready;
      remain_reg      <= remain_next;
`ifdef FRAME_CHECKSUM_EN
      sum_reg         <= sum_next;
`endif
      tmo_reg         <= tmo_next;
      frame_start_reg <= start_next;
      frame_ok_reg    <= ok_next;
      frame_err_reg   <= err_next;
      err_code_reg    <= code_next;

      // Flush overrides any same-cycle push or pop.
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + (AW+1)'(1);
          2'b01:   count_reg <= count_reg - (AW+1)'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // FIFO storage. Push and flush are mutually exclusive, and occupancy is
  // reset separately, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {push_last, rx_data};
    end
  end

endmodule
